mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-channel global data-memory arbiter.
- Shares one memory port between NUM_CONSUMERS load/store requesters (per-thread LSUs of all cores).
- Round-robin grant, one outstanding transaction at a time.
- Sits between the cores' LSU request buses and the external data-memory interface, under the top level alongside dispatch.

Parameters:
- NUM_CONSUMERS, 4, number of requesters (≥2).
- ADDR_BITS, 8, memory address width.
- DATA_BITS, 8, memory data width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- consumer_read_valid  in  [NUM_CONSUMERS]  read request; held until its ready drops
- consumer_read_address  in  [NUM_CONSUMERS][ADDR_BITS]  read address
- consumer_read_ready  out  [NUM_CONSUMERS]  read complete; held until valid drops
- consumer_read_data  out  [NUM_CONSUMERS][DATA_BITS]  read data, valid while ready
- consumer_write_valid  in  [NUM_CONSUMERS]  write request
- consumer_write_address  in  [NUM_CONSUMERS][ADDR_BITS]  write address
- consumer_write_data  in  [NUM_CONSUMERS][DATA_BITS]  write data
- consumer_write_ready  out  [NUM_CONSUMERS]  write complete; held until valid drops
- mem_read_valid  out  1  read request to memory
- mem_read_address  out  ADDR_BITS  memory read address
- mem_read_ready  in  1  memory read done; data valid same cycle
- mem_read_data  in  DATA_BITS  memory read data
- mem_write_valid  out  1  write request to memory
- mem_write_address  out  ADDR_BITS  memory write address
- mem_write_data  out  DATA_BITS  memory write data
- mem_write_ready  in  1  memory write accepted
- busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs registered. Clock is clk; reset is synchronous and active-high.
- Reset: all outputs 0 (including consumer_read_data), state=IDLE, rr_ptr=0, grant=0.
- State IDLE:
  - Starting at rr_ptr, search indices rr_ptr, rr_ptr+1, ... wrapping modulo NUM_CONSUMERS.
  - Pick the first requester with read_valid or write_valid asserted, latch it as grant.
  - If that requester asserts both, read wins: the write stays pending and is served in a later grant.
  - Read grant: mem_read_valid<=1, mem_read_address<=consumer_read_address[grant], go to READ_WAIT.
  - Write grant: mem_write_valid<=1, mem_write_address/data<=consumer values, go to WRITE_WAIT.
  - No request: stay in IDLE.
- READ_WAIT: on mem_read_ready, mem_read_valid<=0, consumer_read_data[grant]<=mem_read_data, consumer_read_ready[grant]<=1, go to READ_RELAY.
- WRITE_WAIT: on mem_write_ready, mem_write_valid<=0, consumer_write_ready[grant]<=1, go to WRITE_RELAY.
- READ_RELAY / WRITE_RELAY:
  - When the matching consumer valid[grant]==0: ready[grant]<=0, rr_ptr<=(grant+1) mod N, go to IDLE.
  - consumer_read_data[grant] keeps its value after ready drops, until overwritten.
- Latency:
  - Consumer valid sampled in IDLE at cycle t; mem valid high at t+1.
  - mem ready sampled at cycle u; consumer ready high at u+1.
  - Minimum request-to-ready: 2 cycles.
  - After valid drops, at least 1 IDLE cycle before the next grant.
- Rules and boundaries:
  - Only the granted requester's address/data are sampled, once, at grant. Later changes are ignored.
  - Consumer dropping valid during a WAIT state is a protocol violation. The memory transaction still completes; RELAY exits on the next cycle.
  - The mem ready strobe is only honoured in the matching WAIT state; it is ignored elsewhere.
  - rr_ptr wraps from N-1 to 0. A requester that is continuously requesting is served within N grants.
  - Reset in any state aborts immediately. mem valid drops the next cycle; the memory side must tolerate the abandoned request.

Decomposition:
- Package gpu_mem_pkg:
  - arb_state_t enum: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
  - Default ADDR_BITS/DATA_BITS constants shared with the LSU and top level.
- Sub-module rr_picker: combinational round-robin priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: found, index.

Test Plan (N=4, ADDR_BITS=8, DATA_BITS=8):
- Single read: requester 2 reads 0x10; memory gives ready with 0xAB 3 cycles after mem_read_valid → mem_read_address=0x10; consumer_read_ready[2]=1 with data 0xAB one cycle after mem_read_ready; ready drops one cycle after valid[2] drops; busy returns to 0.
- All four read simultaneously, valid held until served → grant order 0,1,2,3; second round starts again at 0 (wrap).
- Fairness: after serving requester 1, requesters 0 and 3 both request → 3 is served before 0.
- Requester 1 asserts read 0x04 and write 0x08/0x5A together → read served first; write then reaches memory with address 0x08, data 0x5A; consumer_write_ready[1]=1.
- Zero-latency memory (ready asserted the cycle valid rises) → consumer ready 2 cycles after consumer valid is sampled; no double transaction.
- Reset asserted in READ_WAIT → next cycle all outputs 0, busy=0; a fresh request from requester 3 is served first, since rr_ptr=0 and 3 is the only requester.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// rtl/gpu_mem_pkg.sv - shared data-memory types and default widths
package gpu_mem_pkg;

  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int DEFAULT_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    READ_RELAY,
    WRITE_RELAY
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rtl/mem_arbiter_rr_picker.sv - combinational round-robin priority encoder
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset back to rr_ptr so the nearest requester wins last.
  always_comb begin
    found = 1'b0;
    index = '0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IDX_W'((int'(rr_ptr) + i) % N);
      if (req[idx]) begin
        found = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin single-port data-memory arbiter
module mem_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS     = DEFAULT_DATA_BITS
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic                                    mem_read_valid,
  output logic [ADDR_BITS-1:0]                    mem_read_address,
  input  logic                                    mem_read_ready,
  input  logic [DATA_BITS-1:0]                    mem_read_data,
  output logic                                    mem_write_valid,
  output logic [ADDR_BITS-1:0]                    mem_write_address,
  output logic [DATA_BITS-1:0]                    mem_write_data,
  input  logic                                    mem_write_ready,
  output logic                                    busy
);

  localparam int IDX_W = $clog2(NUM_CONSUMERS);

  arb_state_t state, state_n;
  logic [IDX_W-1:0] grant, grant_n, rr_ptr, rr_ptr_n, pick_index, next_ptr;
  logic pick_found;

  logic [NUM_CONSUMERS-1:0]                consumer_read_ready_n, consumer_write_ready_n;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data_n;
  logic                                    mem_read_valid_n, mem_write_valid_n, busy_n;
  logic [ADDR_BITS-1:0]                    mem_read_address_n, mem_write_address_n;
  logic [DATA_BITS-1:0]                    mem_write_data_n;

  rr_picker #(.N(NUM_CONSUMERS), .IDX_W(IDX_W)) u_picker (
    .req    (consumer_read_valid | consumer_write_valid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .index  (pick_index)
  );

  assign next_ptr = (grant == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      grant                <= '0;
      rr_ptr               <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      busy                 <= 1'b0;
    end else begin
      state                <= state_n;
      grant                <= grant_n;
      rr_ptr               <= rr_ptr_n;
      consumer_read_ready  <= consumer_read_ready_n;
      consumer_read_data   <= consumer_read_data_n;
      consumer_write_ready <= consumer_write_ready_n;
      mem_read_valid       <= mem_read_valid_n;
      mem_read_address     <= mem_read_address_n;
      mem_write_valid      <= mem_write_valid_n;
      mem_write_address    <= mem_write_address_n;
      mem_write_data       <= mem_write_data_n;
      busy                 <= busy_n;
    end
  end

  always_comb begin
    state_n                = state;
    grant_n                = grant;
    rr_ptr_n               = rr_ptr;
    consumer_read_ready_n  = consumer_read_ready;
    consumer_read_data_n   = consumer_read_data;
    consumer_write_ready_n = consumer_write_ready;
    mem_read_valid_n       = mem_read_valid;
    mem_read_address_n     = mem_read_address;
    mem_write_valid_n      = mem_write_valid;
    mem_write_address_n    = mem_write_address;
    mem_write_data_n       = mem_write_data;

    case (state)
      IDLE: begin
        // A requester with both read and write pending gets its read first.
        if (pick_found) begin
          grant_n = pick_index;
          if (consumer_read_valid[pick_index]) begin
            mem_read_valid_n   = 1'b1;
            mem_read_address_n = consumer_read_address[pick_index];
            state_n            = READ_WAIT;
          end else begin
            mem_write_valid_n   = 1'b1;
            mem_write_address_n = consumer_write_address[pick_index];
            mem_write_data_n    = consumer_write_data[pick_index];
            state_n             = WRITE_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          mem_read_valid_n            = 1'b0;
          consumer_read_data_n[grant] = mem_read_data;
          consumer_read_ready_n[grant] = 1'b1;
          state_n                     = READ_RELAY;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          mem_write_valid_n             = 1'b0;
          consumer_write_ready_n[grant] = 1'b1;
          state_n                       = WRITE_RELAY;
        end
      end
      READ_RELAY: begin
        if (!consumer_read_valid[grant]) begin
          consumer_read_ready_n[grant] = 1'b0;
          rr_ptr_n                     = next_ptr;
          state_n                      = IDLE;
        end
      end
      WRITE_RELAY: begin
        if (!consumer_write_valid[grant]) begin
          consumer_write_ready_n[grant] = 1'b0;
          rr_ptr_n                      = next_ptr;
          state_n                       = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]         rvalid, wvalid, rready_o, wready_o;
  logic [N-1:0][AW-1:0] raddr, waddr;
  logic [N-1:0][DW-1:0] wdata, rdata_o;
  logic                 mrv, mwv, mrr, mwr, busy;
  logic [AW-1:0]        mra, mwa;
  logic [DW-1:0]        mrd, mwd;

  mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (rvalid),
    .consumer_read_address  (raddr),
    .consumer_read_ready    (rready_o),
    .consumer_read_data     (rdata_o),
    .consumer_write_valid   (wvalid),
    .consumer_write_address (waddr),
    .consumer_write_data    (wdata),
    .consumer_write_ready   (wready_o),
    .mem_read_valid         (mrv),
    .mem_read_address       (mra),
    .mem_read_ready         (mrr),
    .mem_read_data          (mrd),
    .mem_write_valid        (mwv),
    .mem_write_address      (mwa),
    .mem_write_data         (mwd),
    .mem_write_ready        (mwr),
    .busy                   (busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: fixed latency or combinational (zero latency) handshake.
  int   lat = 1;
  bit   zero_lat = 1'b0;
  int   rcnt = 0, wcnt = 0;
  logic rd_r = 1'b0, wr_r = 1'b0, stray = 1'b0;
  logic [DW-1:0] mem_store [256];
  bit            ml_wr   [$];
  logic [AW-1:0] ml_addr [$];
  logic [DW-1:0] ml_data [$];
  int            ml_cyc  [$];

  assign mrr = (zero_lat ? mrv : rd_r) | stray;
  assign mwr = (zero_lat ? mwv : wr_r) | stray;
  assign mrd = mem_store[mra];

  initial begin
    forever begin
      @(negedge clk);
      if (mrv) begin rcnt++; rd_r = (rcnt > lat); end
      else begin rcnt = 0; rd_r = 1'b0; end
      if (mwv) begin wcnt++; wr_r = (wcnt > lat); end
      else begin wcnt = 0; wr_r = 1'b0; end
      if (mrv && (zero_lat || rd_r)) begin
        ml_wr.push_back(1'b0); ml_addr.push_back(mra);
        ml_data.push_back(mem_store[mra]); ml_cyc.push_back(cyc);
      end
      if (mwv && (zero_lat || wr_r)) begin
        ml_wr.push_back(1'b1); ml_addr.push_back(mwa);
        ml_data.push_back(mwd); ml_cyc.push_back(cyc);
        mem_store[mwa] = mwd;
      end
    end
  end

  // Reference model: pending requests served in round-robin order, reads before writes.
  logic [DW-1:0] ref_mem [256];
  int            ref_ptr = 0;
  int            exp_id   [$];
  bit            exp_wr   [$];
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];

  task automatic model_round();
    bit pr [N];
    bit pw [N];
    int g;
    exp_id.delete(); exp_wr.delete(); exp_addr.delete(); exp_data.delete();
    for (int i = 0; i < N; i++) begin pr[i] = rvalid[i]; pw[i] = wvalid[i]; end
    while (1) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && (pr[(ref_ptr + k) % N] || pw[(ref_ptr + k) % N])) g = (ref_ptr + k) % N;
      if (g < 0) break;
      exp_id.push_back(g);
      if (pr[g]) begin
        exp_wr.push_back(1'b0); exp_addr.push_back(raddr[g]);
        exp_data.push_back(ref_mem[raddr[g]]); pr[g] = 1'b0;
      end else begin
        exp_wr.push_back(1'b1); exp_addr.push_back(waddr[g]);
        exp_data.push_back(wdata[g]); ref_mem[waddr[g]] = wdata[g]; pw[g] = 1'b0;
      end
      ref_ptr = (g + 1) % N;
    end
  endtask

  int            c_id   [$];
  bit            c_wr   [$];
  logic [DW-1:0] c_data [$];
  int            c_cyc  [$];

  task automatic clear_logs();
    ml_wr.delete(); ml_addr.delete(); ml_data.delete(); ml_cyc.delete();
  endtask

  // Consumers hold valid until ready, then drop it; returns ok=0 on timeout.
  task automatic run_traffic(input int budget, output bit ok);
    int c = 0;
    c_id.delete(); c_wr.delete(); c_data.delete(); c_cyc.delete();
    while (((rvalid | wvalid) != '0) && c < budget) begin
      @(negedge clk); c++;
      for (int i = 0; i < N; i++) begin
        if (rvalid[i] && rready_o[i]) begin
          c_id.push_back(i); c_wr.push_back(1'b0); c_data.push_back(rdata_o[i]);
          c_cyc.push_back(cyc); rvalid[i] = 1'b0;
        end else if (wvalid[i] && wready_o[i]) begin
          c_id.push_back(i); c_wr.push_back(1'b1); c_data.push_back('0);
          c_cyc.push_back(cyc); wvalid[i] = 1'b0;
        end
      end
    end
    c = 0;
    while (busy && c < 10) begin @(negedge clk); c++; end
    ok = ((rvalid | wvalid) == '0) && !busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({rready_o, wready_o, rdata_o, mrv, mra, mwv, mwa, mwd, busy} !== '0) begin
      fails++; $display("FAIL reset_outputs: got nonzero output (busy=%b mrv=%b mwv=%b) expected all 0", busy, mrv, mwv);
    end
    reset = 1'b0;
    ref_ptr = 0;
    stray = 1'b1;
    repeat (3) @(negedge clk);
    stray = 1'b0;
    tests++;
    if (busy !== 1'b0 || rready_o !== '0 || wready_o !== '0) begin
      fails++; $display("FAIL stray_ready_idle: busy=%b rready=%b wready=%b expected 0", busy, rready_o, wready_o);
    end
  endtask

  task automatic test_single_read();
    int k = 0;
    lat = 3; zero_lat = 1'b0;
    mem_store[8'h10] = 8'hAB; ref_mem[8'h10] = 8'hAB;
    clear_logs();
    raddr[2] = 8'h10; rvalid[2] = 1'b1;
    @(negedge clk); k++;
    tests++;
    if (mrv !== 1'b1 || mra !== 8'h10 || busy !== 1'b1) begin
      fails++; $display("FAIL single_mem_req: mrv=%b addr=%h busy=%b expected 1/10/1", mrv, mra, busy);
    end
    raddr[2] = 8'h77;
    @(negedge clk); k++;
    tests++;
    if (mra !== 8'h10) begin fails++; $display("FAIL single_addr_hold: got %h expected 10", mra); end
    while (!rready_o[2] && k < 20) begin @(negedge clk); k++; end
    tests++;
    if (k != 5) begin fails++; $display("FAIL single_latency: got %0d expected 5", k); end
    tests++;
    if (rdata_o[2] !== 8'hAB) begin fails++; $display("FAIL single_data: got %h expected ab", rdata_o[2]); end
    tests++;
    if (ml_cyc.size() != 1 || cyc != ml_cyc[0] + 1) begin
      fails++; $display("FAIL single_ready_delay: log size %0d cyc %0d expected one ready one cycle earlier", ml_cyc.size(), cyc);
    end
    rvalid[2] = 1'b0;
    @(negedge clk);
    tests++;
    if (rready_o[2] !== 1'b0 || rdata_o[2] !== 8'hAB || busy !== 1'b0) begin
      fails++; $display("FAIL single_release: ready=%b data=%h busy=%b expected 0/ab/0", rready_o[2], rdata_o[2], busy);
    end
    ref_ptr = 3;
  endtask

  task automatic test_all_read_wrap();
    bit ok;
    reset = 1'b1; @(negedge clk); reset = 1'b0; ref_ptr = 0;
    lat = $urandom_range(0, 2);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin raddr[i] = 8'($urandom); rvalid[i] = 1'b1; end
      model_round(); clear_logs();
      run_traffic(200, ok);
      tests++;
      if (!ok || c_id.size() != N) begin
        fails++; $display("FAIL all_read_done round %0d: served %0d expected %0d", r, c_id.size(), N);
      end
      for (int k = 0; k < N && k < c_id.size(); k++) begin
        tests++;
        if (c_id[k] != k || c_data[k] !== exp_data[k]) begin
          fails++; $display("FAIL all_read_order round %0d slot %0d: id %0d data %h expected id %0d data %h", r, k, c_id[k], c_data[k], k, exp_data[k]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    bit ok;
    raddr[1] = 8'h21; rvalid[1] = 1'b1;
    model_round(); clear_logs(); run_traffic(100, ok);
    raddr[0] = 8'h30; raddr[3] = 8'h33; rvalid[0] = 1'b1; rvalid[3] = 1'b1;
    model_round(); clear_logs(); run_traffic(100, ok);
    tests++;
    if (!ok || c_id.size() != 2 || c_id[0] != 3 || c_id[1] != 0) begin
      fails++; $display("FAIL fairness_order: got %p expected '{3, 0}", c_id);
    end
  endtask

  task automatic test_read_write_same();
    bit ok;
    raddr[1] = 8'h04; waddr[1] = 8'h08; wdata[1] = 8'h5A;
    rvalid[1] = 1'b1; wvalid[1] = 1'b1;
    model_round(); clear_logs(); run_traffic(100, ok);
    tests++;
    if (!ok || c_id.size() != 2 || c_wr.size() != 2 || c_wr[0] != 1'b0 || c_wr[1] != 1'b1) begin
      fails++; $display("FAIL rw_order: got kinds %p expected read then write", c_wr);
    end
    tests++;
    if (ml_wr.size() != 2 || ml_addr[0] !== 8'h04 || ml_addr[1] !== 8'h08 || ml_data[1] !== 8'h5A) begin
      fails++; $display("FAIL rw_mem_bus: got addrs %p data %p expected 04 then 08/5a", ml_addr, ml_data);
    end
    tests++;
    if (c_data.size() < 1 || c_data[0] !== exp_data[0]) begin
      fails++; $display("FAIL rw_read_data: got %p expected %h", c_data, exp_data[0]);
    end
  endtask

  task automatic test_zero_latency();
    int k;
    zero_lat = 1'b1;
    for (int w = 0; w < 2; w++) begin
      clear_logs(); k = 0;
      if (w == 0) begin raddr[0] = 8'h44; rvalid[0] = 1'b1; end
      else begin waddr[2] = 8'h45; wdata[2] = 8'hC3; wvalid[2] = 1'b1; end
      while (!(w == 0 ? rready_o[0] : wready_o[2]) && k < 20) begin @(negedge clk); k++; end
      tests++;
      if (k != 2) begin fails++; $display("FAIL zero_lat_latency kind %0d: got %0d expected 2", w, k); end
      rvalid[0] = 1'b0; wvalid[2] = 1'b0;
      repeat (4) @(negedge clk);
      tests++;
      if (ml_wr.size() != 1 || ml_wr[0] != bit'(w) || busy !== 1'b0) begin
        fails++; $display("FAIL zero_lat_single_txn kind %0d: got %0d transactions busy=%b expected 1/0", w, ml_wr.size(), busy);
      end
    end
    ref_mem[8'h45] = 8'hC3;
    ref_ptr = 3;
    zero_lat = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    lat = 1000;
    raddr[1] = 8'h55; rvalid[1] = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (mrv !== 1'b1) begin fails++; $display("FAIL reset_pre_wait: mrv got %b expected 1", mrv); end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({rready_o, wready_o, rdata_o, mrv, mra, mwv, mwa, mwd, busy} !== '0) begin
      fails++; $display("FAIL reset_in_wait: busy=%b mrv=%b mra=%h expected all 0", busy, mrv, mra);
    end
    reset = 1'b0; rvalid[1] = 1'b0; ref_ptr = 0; lat = 1;
    @(negedge clk);
    raddr[3] = 8'h66; rvalid[3] = 1'b1;
    model_round(); clear_logs(); run_traffic(100, ok);
    tests++;
    if (!ok || c_id.size() != 1 || c_id[0] != 3 || ml_addr.size() != 1 || ml_addr[0] !== 8'h66) begin
      fails++; $display("FAIL reset_fresh_grant: got ids %p addrs %p expected '{3} at 66", c_id, ml_addr);
    end
  endtask

  task automatic test_random();
    bit ok;
    int op;
    for (int r = 0; r < 25; r++) begin
      zero_lat = ($urandom_range(0, 3) == 0);
      lat = $urandom_range(0, 3);
      for (int i = 0; i < N; i++) begin
        op = $urandom_range(0, 3);
        raddr[i] = 8'($urandom_range(0, 15)); waddr[i] = 8'($urandom_range(0, 15));
        wdata[i] = 8'($urandom);
        rvalid[i] = op[0]; wvalid[i] = op[1];
      end
      model_round(); clear_logs();
      run_traffic(300, ok);
      tests++;
      if (!ok || c_id.size() != exp_id.size() || ml_wr.size() != exp_id.size()) begin
        fails++; $display("FAIL rand_count round %0d: served %0d mem %0d expected %0d", r, c_id.size(), ml_wr.size(), exp_id.size());
      end
      for (int k = 0; k < exp_id.size() && k < c_id.size() && k < ml_wr.size(); k++) begin
        tests++;
        if (c_id[k] != exp_id[k] || c_wr[k] != exp_wr[k] || ml_wr[k] != exp_wr[k] ||
            ml_addr[k] !== exp_addr[k] || (exp_wr[k] ? ml_data[k] : c_data[k]) !== exp_data[k] ||
            c_cyc[k] != ml_cyc[k] + 1) begin
          fails++;
          $display("FAIL rand_txn round %0d slot %0d: id %0d wr %0d addr %h data %h dly %0d expected id %0d wr %0d addr %h data %h dly 1",
                   r, k, c_id[k], c_wr[k], ml_addr[k], exp_wr[k] ? ml_data[k] : c_data[k], c_cyc[k] - ml_cyc[k],
                   exp_id[k], exp_wr[k], exp_addr[k], exp_data[k]);
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    zero_lat = 1'b0;
  endtask

  initial begin
    rvalid = '0; wvalid = '0; raddr = '0; waddr = '0; wdata = '0;
    for (int a = 0; a < 256; a++) begin
      mem_store[a] = 8'($urandom);
      ref_mem[a] = mem_store[a];
    end
    test_reset();
    test_single_read();
    test_all_read_wrap();
    test_fairness();
    test_read_write_same();
    test_zero_latency();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

endmodule
